// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time,
// hands fetched words to decode over valid/ready, handles redirects and flags a
// hung memory with a sticky timeout error.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StOut,
        StErr
    } state_e;

    // Counter limit widened by one bit so the increment never aliases the limit.
    localparam logic [8:0] TMO_LIM = 9'(TIMEOUT);

    state_e      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic [31:0] r_inst_pc, w_inst_pc_nxt;
    logic        r_pend, w_pend_nxt;
    logic [31:0] r_pend_pc, w_pend_pc_nxt;
    logic [7:0]  r_tmo_cnt, w_tmo_cnt_nxt;

    logic [31:0] w_target;
    logic [8:0]  w_cnt_inc;
    logic        w_tmo_hit;

    assign w_target  = {i_redirect_pc[31:2], 2'b00};
    assign w_cnt_inc = {1'b0, r_tmo_cnt} + 9'd1;
    assign w_tmo_hit = (w_cnt_inc >= TMO_LIM);

    // State, PC, captured instruction, pending redirect and timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_pc      <= RESET_PC;
            r_inst    <= 32'd0;
            r_inst_pc <= 32'd0;
            r_pend    <= 1'b0;
            r_pend_pc <= 32'd0;
            r_tmo_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    // Next-state logic for the fetch sequence, redirects and timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_tmo_cnt_nxt = r_tmo_cnt;

        unique case (r_state)
            StIdle: begin
                if (i_redirect_valid) begin
                    w_pc_nxt = w_target;
                end
                if (i_start) begin
                    w_state_nxt   = StReq;
                    w_tmo_cnt_nxt = 8'd0;
                end
            end
            StReq: begin
                w_tmo_cnt_nxt = w_cnt_inc[7:0];
                // The request in flight keeps its address; the redirect waits.
                if (i_redirect_valid) begin
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_target;
                end
                if (i_mem_req_ready) begin
                    w_state_nxt = StWait;
                end else if (w_tmo_hit) begin
                    w_state_nxt = StErr;
                end
            end
            StWait: begin
                w_tmo_cnt_nxt = w_cnt_inc[7:0];
                if (i_mem_rsp_valid) begin
                    if (r_pend || i_redirect_valid) begin
                        // Stale response: drop it and refetch from the newest target.
                        w_pc_nxt      = i_redirect_valid ? w_target : r_pend_pc;
                        w_pend_nxt    = 1'b0;
                        w_state_nxt   = StReq;
                        w_tmo_cnt_nxt = 8'd0;
                    end else begin
                        w_inst_nxt    = i_mem_rsp_data;
                        w_inst_pc_nxt = r_pc;
                        w_pc_nxt      = r_pc + 32'd4;
                        w_state_nxt   = StOut;
                    end
                end else begin
                    if (i_redirect_valid) begin
                        w_pend_nxt    = 1'b1;
                        w_pend_pc_nxt = w_target;
                    end
                    if (w_tmo_hit) begin
                        w_state_nxt = StErr;
                    end
                end
            end
            StOut: begin
                if (i_redirect_valid) begin
                    w_pc_nxt      = w_target;
                    w_state_nxt   = StReq;
                    w_tmo_cnt_nxt = 8'd0;
                end else if (i_inst_ready) begin
                    w_state_nxt   = StReq;
                    w_tmo_cnt_nxt = 8'd0;
                end
            end
            StErr: begin
                w_state_nxt = StErr;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_mem_req_valid = (r_state == StReq);
    assign o_mem_req_addr  = r_pc;
    assign o_inst_valid    = (r_state == StOut);
    assign o_inst          = r_inst;
    assign o_inst_pc       = r_inst_pc;
    assign o_busy          = (r_state != StIdle) && (r_state != StErr);
    assign o_err           = (r_state == StErr);

endmodule
